// File: rtl/load_store_unit_if.sv
// Data-memory request/grant/response bus between the load/store unit and memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: multi-cycle data-memory access with byte-lane
// steering, masking and sign/zero extension of load results.
// Optional macro LSU_MISALIGNED_TRAP_EN: misaligned halfword/word accesses
// complete without a bus request and raise the misaligned flag.
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        bus_error,
`ifdef LSU_MISALIGNED_TRAP_EN
  output logic        misaligned,
`endif
  load_store_unit_if.master mem
);

  localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    addr_lo_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          req;

  logic        is_load, is_store, legal, mis_addr, accept, go_req, tmo_hit, abort;
  logic [31:0] wdata_d;
  logic [3:0]  mask_d;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] ld_ext;

  // Decode the incoming request and classify it.
  always_comb begin
    is_load  = (opcode == 7'b0000011);
    is_store = (opcode == 7'b0100011);
    legal    = 1'b0;
    if (is_load)
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (funct3 == 3'b100) || (funct3 == 3'b101);
    else if (is_store)
      legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
`ifdef LSU_MISALIGNED_TRAP_EN
    mis_addr = ((funct3[1:0] == 2'b01) && address[0]) ||
               ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
`else
    mis_addr = 1'b0;
`endif
    accept  = (state_q == IDLE) && start && (is_load || is_store);
    go_req  = accept && legal && !mis_addr;
    tmo_hit = (MEM_TIMEOUT != 0) && (32'(cnt_q) == MEM_TIMEOUT - 32'd1);
    abort   = tmo_hit && (((state_q == REQ) && !mem.mem_gnt) ||
                          ((state_q == WAIT) && !mem.mem_rvalid));
  end

  // Store lane replication and byte enables; loads read the whole word.
  always_comb begin
    wdata_d = '0;
    mask_d  = '1;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata_d = {4{store_data[7:0]}};
          mask_d  = 4'b0001 << address[1:0];
        end
        2'b01: begin
          wdata_d = {2{store_data[15:0]}};
          mask_d  = address[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_d = store_data;
          mask_d  = '1;
        end
      endcase
    end
  end

  // Select and extend the addressed lane of the returned read word.
  always_comb begin
    case (addr_lo_q)
      2'd0:    lane_byte = mem.mem_rdata[7:0];
      2'd1:    lane_byte = mem.mem_rdata[15:8];
      2'd2:    lane_byte = mem.mem_rdata[23:16];
      default: lane_byte = mem.mem_rdata[31:24];
    endcase
    lane_half = addr_lo_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  ld_ext = {24'd0, lane_byte};
      3'b001:  ld_ext = {{16{lane_half[15]}}, lane_half};
      3'b101:  ld_ext = {16'd0, lane_half};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a grant or response on the expiry cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = go_req ? REQ : DONE;
      REQ: begin
        if (mem.mem_gnt) state_d = we_q ? DONE : WAIT;
        else if (tmo_hit) state_d = DONE;
      end
      WAIT: if (mem.mem_rvalid || tmo_hit) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Status and bus-request outputs decoded from the state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    req  = (state_q == REQ);
  end

  // Timeout counter restarts on every state change and runs in REQ/WAIT.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if ((state_q == REQ) || (state_q == WAIT)) cnt_q <= cnt_q + 1'b1;
  end

  // Access latches and result/status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo_q <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      load_data <= '0;
      bus_error <= 1'b0;
`ifdef LSU_MISALIGNED_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      if (accept) begin
        load_data <= '0;
        bus_error <= 1'b0;
`ifdef LSU_MISALIGNED_TRAP_EN
        misaligned <= legal && mis_addr;
`endif
      end
      if (go_req) begin
        addr_lo_q <= address[1:0];
        f3_q      <= funct3;
        we_q      <= is_store;
        addr_q    <= {address[31:2], 2'b00};
        wdata_q   <= wdata_d;
        mask_q    <= mask_d;
      end
      if ((state_q == WAIT) && mem.mem_rvalid) load_data <= ld_ext;
      if (abort) bus_error <= 1'b1;
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_mask  = mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses checked cycle by cycle against a transaction-level model.
module tb_load_store_unit;

  localparam int unsigned TMO = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] address, store_data;
  logic        busy, done, bus_error;
  logic [31:0] load_data;
`ifdef LSU_MISALIGNED_TRAP_EN
  logic        misaligned;
`endif

  load_store_unit_if bus();

  load_store_unit #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct3(funct3),
    .address(address), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .bus_error(bus_error),
`ifdef LSU_MISALIGNED_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_ld  = '0;
  logic        exp_be  = 1'b0;
  logic        exp_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    int unsigned sh;
    case (f3)
      3'b000, 3'b100: begin
        sh = 8 * int'(a % 4);
        v  = (rd >> sh) & 32'hFF;
        if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
      end
      3'b001, 3'b101: begin
        sh = 16 * int'((a / 2) % 2);
        v  = (rd >> sh) & 32'hFFFF;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // One access: g = cycles of mem_req before grant, r = WAIT cycles before rvalid.
  task automatic do_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input int g, input int r,
                           input logic [31:0] rd, input bit noise);
    bit is_ld, is_st, legal, mis;
    int n_req, done_at, last, size;
    logic [31:0] e_wd;
    logic [3:0]  e_mask;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    size  = int'(f3 % 4);
    if (is_ld) legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else       legal = is_st && (f3 <= 2);
`ifdef LSU_MISALIGNED_TRAP_EN
    mis = legal && ((size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0));
`else
    mis = 1'b0;
`endif
    e_mask = 4'hF;
    e_wd   = sd;
    if (size == 0) begin
      e_mask = 4'(1 << (a % 4));
      e_wd   = (sd & 32'hFF) * 32'h01010101;
    end else if (size == 1) begin
      e_mask = ((a / 2) % 2 != 0) ? 4'hC : 4'h3;
      e_wd   = (sd & 32'hFFFF) * 32'h00010001;
    end
    if (is_ld) e_mask = 4'hF;

    n_req = 0;
    done_at = -1;
    if (is_ld || is_st) begin
      exp_ld = '0; exp_be = 1'b0; exp_mis = mis;
      if (!legal || mis) done_at = 0;
      else if (g >= int'(TMO)) begin
        n_req = TMO; done_at = TMO; exp_be = 1'b1;
      end else if (is_st) begin
        n_req = g + 1; done_at = g + 1;
      end else begin
        n_req = g + 1;
        if (r < int'(TMO)) begin
          done_at = g + 2 + r; exp_ld = ref_load(f3, a, rd);
        end else begin
          done_at = g + 1 + TMO; exp_be = 1'b1;
        end
      end
    end
    last = (done_at < 0) ? 0 : done_at + 1;

    opcode = op; funct3 = f3; address = a; store_data = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= last; c++) begin
      check("busy", 32'(busy), 32'(done_at >= 0 && c <= done_at));
      check("done", 32'(done), 32'(c == done_at));
      check("mem_req", 32'(bus.mem_req), 32'(c < n_req));
      if (c < n_req) begin
        check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        check("mem_mask", 32'(bus.mem_mask), 32'(e_mask));
        check("mem_we", 32'(bus.mem_we), 32'(is_st));
        if (is_st) check("mem_wdata", bus.mem_wdata, e_wd);
      end
      if (c == done_at || c == last) begin
        check("load_data", load_data, exp_ld);
        check("bus_error", 32'(bus_error), 32'(exp_be));
`ifdef LSU_MISALIGNED_TRAP_EN
        check("misaligned", 32'(misaligned), 32'(exp_mis));
`endif
      end
      bus.mem_gnt    = (c == g);
      bus.mem_rvalid = (is_ld && c == g + 1 + r) || (noise && c <= g && $urandom_range(0, 1) == 1);
      bus.mem_rdata  = (c == g + 1 + r) ? rd : $urandom;
      if (noise && c < last) begin
        start = ($urandom_range(0, 1) == 1);
        opcode = OP_LOAD; funct3 = 3'($urandom); address = $urandom;
      end else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [3];
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b1100011;
    reset = 1'b1; start = 1'b0; opcode = '0; funct3 = '0; address = '0; store_data = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_load_data", load_data, 0);
    check("rst_bus_error", 32'(bus_error), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_mask", 32'(bus.mem_mask), 0);
    reset = 1'b0;

    // Directed cases.
    do_access(OP_LOAD, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0);
    do_access(OP_LOAD, 3'b000, 32'h203, 0, 0, 0, 32'h80FF1234, 0);
    do_access(OP_LOAD, 3'b100, 32'h203, 0, 0, 0, 32'h80FF1234, 0);
    do_access(OP_STORE, 3'b001, 32'h302, 32'h0000ABCD, 3, 0, 0, 0);
    do_access(OP_LOAD, 3'b010, 32'h104, 0, 9, 0, 0, 0);
    do_access(OP_LOAD, 3'b001, 32'h002, 0, 0, 3, 32'h9234_5678, 0);
    do_access(OP_LOAD, 3'b101, 32'h010, 0, 0, 5, 32'h1111_2222, 0);
    do_access(OP_LOAD, 3'b011, 32'h010, 0, 0, 0, 0, 0);
    do_access(OP_STORE, 3'b010, 32'h101, 32'h1234_5678, 0, 0, 0, 0);
    do_access(ops[0], 3'b000, 32'h0, 0, 0, 0, 0, 0);

    // Reset while waiting for read data abandons the access.
    opcode = OP_LOAD; funct3 = 3'b010; address = 32'h40; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    check("wait_busy", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ld = '0; exp_be = 1'b0; exp_mis = 1'b0;
    check("rstw_busy", 32'(busy), 0);
    check("rstw_mem_req", 32'(bus.mem_req), 0);
    check("rstw_load_data", load_data, 0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'b0;
      check("rstw_done", 32'(done), 0);
      check("rstw_busy2", 32'(busy), 0);
    end
    do_access(OP_LOAD, 3'b010, 32'h40, 0, 1, 1, 32'h0BAD_F00D, 0);

    // Randomized accesses.
    for (int n = 0; n < 160; n++) begin
      int k;
      logic [6:0] op;
      k = int'($urandom_range(0, 9));
      if (k < 4)      op = OP_LOAD;
      else if (k < 8) op = OP_STORE;
      else            op = ops[$urandom_range(0, 2)];
      do_access(op, 3'($urandom), $urandom, $urandom, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 5)), $urandom, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
